// File: rtl/bus_ctl_pkg.sv
//------------------------------------------------------------------------------
// Module   : bus_ctl_pkg
// Purpose  : Shared state encoding and a counter sizing helper for the
//            bus_ctl transfer sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bus_ctl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_REQ     = 3'd1;
  localparam state_t ST_SETUP   = 3'd2;
  localparam state_t ST_DRIVE   = 3'd3;
  localparam state_t ST_RELEASE = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  // One counter serves both setup and timeout, so size it for the larger.
  function automatic int cnt_width(input int setup_cycles, input int timeout_cycles);
    int m;
    m = (setup_cycles > timeout_cycles) ? setup_cycles : timeout_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_ctl_if.sv
//------------------------------------------------------------------------------
// Module   : bus_ctl_if
// Purpose  : Handshake bundle between P-X state control, the bus
//            drivers/receivers and the bus_ctl sequencer.
// Ports    : req, zw, rok, ren, rpe           -> into the sequencer
//            zg, zwzg, dstb, busy, done,
//            oken, pe, alarm                  <- from the sequencer
// Modports : master - the sequencer; slave - the surrounding system.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bus_ctl_if;
  logic req;
  logic zw;
  logic rok;
  logic ren;
  logic rpe;
  logic zg;
  logic zwzg;
  logic dstb;
  logic busy;
  logic done;
  logic oken;
  logic pe;
  logic alarm;

  modport master (
    input  req, zw, rok, ren, rpe,
    output zg, zwzg, dstb, busy, done, oken, pe, alarm
  );

  modport slave (
    output req, zw, rok, ren, rpe,
    input  zg, zwzg, dstb, busy, done, oken, pe, alarm
  );
endinterface

`default_nettype wire

// File: rtl/bus_ctl_sync_n.sv
//------------------------------------------------------------------------------
// Module   : sync_n
// Purpose  : STAGES-deep flop chain bringing an asynchronous level into the
//            clk domain; cleared asynchronously.
// Ports    : clk   in  clock
//            rst_n in  async active-low clear
//            d_i   in  asynchronous level
//            q_o   out synchronized level
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_n #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/bus_ctl.sv
//------------------------------------------------------------------------------
// Module   : bus_ctl
// Purpose  : CPU-side system bus transfer sequencer. Raises zg on a request,
//            drives the bus after grant, strobes dstb, waits for a slave
//            answer and completes the release handshake.
// Ports    : __clk  in  system clock
//            clo_n  in  async active-low general clear
//            bus    bus_ctl_if.master (req/zw/rok/ren/rpe in,
//                   zg/zwzg/dstb/busy/done/oken/pe/alarm out)
// Config   : BUS_CTL_ALARM_EN - enables the answer timeout and alarm flag;
//            when undefined DRIVE/RELEASE wait indefinitely, alarm stays 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_ctl
  import bus_ctl_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic      __clk,
  input  logic      clo_n,
  bus_ctl_if.master bus
);

  localparam int CNT_W = cnt_width(SETUP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT        = {CNT_W{1'b1}};

  // Synchronized copies of the asynchronous inputs: {zw, rok, ren, rpe}
  logic [3:0] async_w;
  logic [3:0] sync_w;

  assign async_w = {bus.zw, bus.rok, bus.ren, bus.rpe};

  for (genvar i = 0; i < 4; i++) begin : g_sync
    sync_n #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (__clk),
      .rst_n (clo_n),
      .d_i   (async_w[i]),
      .q_o   (sync_w[i])
    );
  end

  logic zw_s, rok_s, ren_s, rpe_s, ans_w;
  assign {zw_s, rok_s, ren_s, rpe_s} = sync_w;
  assign ans_w = rok_s | ren_s | rpe_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_w;
  logic             oken_q, oken_d;
  logic             pe_q, pe_d;
  logic             alarm_q, alarm_d;
  logic             tmo_w;
  logic             zg_q, zwzg_q, dstb_q, busy_q, done_q;

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc_w = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef BUS_CTL_ALARM_EN
  localparam logic [CNT_W-1:0] CNT_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // Fires on the edge that would bring the counter to TIMEOUT_CYCLES.
  assign tmo_w = (cnt_q >= CNT_TMO_LAST);
`else
  assign tmo_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oken_d  = oken_q;
    pe_d    = pe_q;
    alarm_d = alarm_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          state_d = ST_REQ;
          cnt_d   = '0;
          oken_d  = 1'b0;
          pe_d    = 1'b0;
          alarm_d = 1'b0;
        end
      end
      ST_REQ: begin
        // Grant wins over a simultaneous request drop: once granted the
        // handshake must run to completion.
        if (zw_s) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
        end else if (!bus.req) begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_SETUP_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_w;
        end
      end
      ST_DRIVE: begin
        if (ans_w) begin
          oken_d  = rok_s | ren_s;
          pe_d    = rpe_s;
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else if (tmo_w) begin
          alarm_d = 1'b1;
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
`ifdef BUS_CTL_ALARM_EN
          cnt_d = cnt_inc_w;
`endif
        end
      end
      ST_RELEASE: begin
        if (!ans_w) begin
          state_d = ST_DONE;
        end else if (tmo_w) begin
          alarm_d = 1'b1;
          state_d = ST_DONE;
        end else begin
`ifdef BUS_CTL_ALARM_EN
          cnt_d = cnt_inc_w;
`endif
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change together with it.
  always_ff @(posedge __clk or negedge clo_n) begin
    if (!clo_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      oken_q  <= 1'b0;
      pe_q    <= 1'b0;
      alarm_q <= 1'b0;
      zg_q    <= 1'b0;
      zwzg_q  <= 1'b0;
      dstb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oken_q  <= oken_d;
      pe_q    <= pe_d;
      alarm_q <= alarm_d;
      zg_q    <= (state_d == ST_REQ)   || (state_d == ST_SETUP) ||
                 (state_d == ST_DRIVE) || (state_d == ST_RELEASE);
      zwzg_q  <= (state_d == ST_SETUP) || (state_d == ST_DRIVE);
      dstb_q  <= (state_d == ST_DRIVE);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.zg    = zg_q;
  assign bus.zwzg  = zwzg_q;
  assign bus.dstb  = dstb_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.oken  = oken_q;
  assign bus.pe    = pe_q;
  assign bus.alarm = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_ctl.sv
//------------------------------------------------------------------------------
// Module   : tb_bus_ctl
// Purpose  : Directed self-checking bench for bus_ctl. Output vector order:
//            {zg, zwzg, dstb, busy, done, oken, pe, alarm}.
// Config   : BUS_CTL_ALARM_EN selects timeout expectations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_ctl;

  localparam int SYNC  = 2;
  localparam int SETUP = 2;
  localparam int TMO   = 64;

  localparam int B_ZWZG = 6;
  localparam int B_DSTB = 5;
  localparam int B_DONE = 3;

  logic clk   = 1'b0;
  logic clo_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  bus_ctl_if bus ();

  bus_ctl #(
    .SYNC_STAGES    (SYNC),
    .SETUP_CYCLES   (SETUP),
    .TIMEOUT_CYCLES (TMO)
  ) u_dut (
    .__clk (clk),
    .clo_n (clo_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {bus.zg, bus.zwzg, bus.dstb, bus.busy, bus.done, bus.oken, bus.pe, bus.alarm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until output bit b is high (bounded); n = edges taken.
  task automatic wait_bit(input string tag, input int b, input int max_cyc, output int n);
    logic [7:0] o;
    n = 0;
    o = outs();
    while (o[b] !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
      o = outs();
    end
    check(tag, {31'd0, o[b]}, 32'd1);
  endtask

  // Answers in DRIVE, releases, waits for done and returns to IDLE.
  task automatic finish_xfer(input string tag, input logic a_ok, input logic a_en, input logic a_pe);
    int n;
    bus.rok = a_ok; bus.ren = a_en; bus.rpe = a_pe;
    repeat (SYNC + 1) tick();
    bus.rok = 1'b0; bus.ren = 1'b0; bus.rpe = 1'b0;
    wait_bit(tag, B_DONE, 10, n);
    bus.req = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int dones;
    bus.req = 1'b0; bus.zw = 1'b0; bus.rok = 1'b0; bus.ren = 1'b0; bus.rpe = 1'b0;

    // Reset state
    repeat (2) tick();
    check("reset_outs", outs(), 8'h00);
    clo_n = 1'b1;
    repeat (2) tick();

    // 1: basic OK transfer with exact timing
    bus.req = 1'b1;
    tick();
    check("t1_zg_latency", outs(), 8'b1001_0000);
    repeat (2) tick();
    bus.zw = 1'b1;
    wait_bit("t1_zwzg_seen", B_ZWZG, 10, n);
    check("t1_zwzg_latency", n, SYNC + 1);
    wait_bit("t1_dstb_seen", B_DSTB, 10, n);
    check("t1_setup_cycles", n, SETUP);
    check("t1_drive", outs(), 8'b1111_0000);
    repeat (5) tick();
    bus.rok = 1'b1;
    repeat (2) tick();
    bus.rok = 1'b0;
    tick();
    check("t1_release", outs(), 8'b1001_0100);
    tick();
    check("t1_release_hold", outs(), 8'b1001_0100);
    tick();
    check("t1_done", outs(), 8'b0001_1100);
    bus.req = 1'b0;
    tick();
    check("t1_idle", outs(), 8'b0000_0100);
    tick();
    check("t1_single_done", outs(), 8'b0000_0100);

    // 2: EN and PE together
    bus.req = 1'b1;
    wait_bit("t2_dstb_seen", B_DSTB, 15, n);
    bus.ren = 1'b1; bus.rpe = 1'b1;
    repeat (SYNC + 1) tick();
    check("t2_release", outs(), 8'b1001_0110);
    bus.ren = 1'b0; bus.rpe = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        dones++;
        bus.req = 1'b0;
      end
    end
    check("t2_done_count", dones, 1);
    check("t2_idle_flags", outs(), 8'b0000_0110);

    // 3: no answer
    bus.req = 1'b1;
    tick();
    check("t3_flags_cleared", outs(), 8'b1001_0000);
    wait_bit("t3_dstb_seen", B_DSTB, 15, n);
`ifdef BUS_CTL_ALARM_EN
    repeat (TMO - 1) tick();
    check("t3_pre_timeout", outs(), 8'b1111_0000);
    tick();
    check("t3_alarm", outs(), 8'b1001_0001);
    tick();
    check("t3_done", outs(), 8'b0001_1001);
    bus.req = 1'b0;
    tick();
    check("t3_idle", outs(), 8'b0000_0001);
    bus.req = 1'b1;
    tick();
    check("t3_alarm_cleared", outs(), 8'b1001_0000);
    wait_bit("t3_dstb2_seen", B_DSTB, 15, n);
    finish_xfer("t3_done2_seen", 1'b1, 1'b0, 1'b0);
`else
    repeat (TMO + 20) tick();
    check("t3_wait_forever", outs(), 8'b1111_0000);
    finish_xfer("t3_done_seen", 1'b1, 1'b0, 1'b0);
    check("t3_idle", outs(), 8'b0000_0100);
`endif

    // 4: request withdrawn before grant
    bus.zw = 1'b0;
    repeat (SYNC + 2) tick();
    bus.req = 1'b1;
    tick();
    check("t4_req", outs(), 8'b1001_0000);
    bus.req = 1'b0;
    tick();
    check("t4_withdrawn", outs(), 8'b0000_0000);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    check("t4_no_done", dones, 0);

    // 5: async clear mid-DRIVE
    bus.req = 1'b1; bus.zw = 1'b1;
    wait_bit("t5_dstb_seen", B_DSTB, 15, n);
    #2;
    clo_n = 1'b0;
    #1;
    check("t5_async_clear", outs(), 8'b0000_0000);
    bus.req = 1'b0; bus.zw = 1'b0;
    tick();
    clo_n = 1'b1;
    tick();
    bus.req = 1'b1; bus.zw = 1'b1;
    tick();
    check("t5_zg_after_clear", outs(), 8'b1001_0000);
    wait_bit("t5_dstb2_seen", B_DSTB, 15, n);
    check("t5_drive", outs(), 8'b1111_0000);
    finish_xfer("t5_done_seen", 1'b1, 1'b0, 1'b0);
    check("t5_idle", outs(), 8'b0000_0100);

    // 6: answer held through RELEASE
    bus.req = 1'b1;
    wait_bit("t6_dstb_seen", B_DSTB, 15, n);
    bus.rok = 1'b1;
    repeat (SYNC + 1) tick();
    check("t6_release", outs(), 8'b1001_0100);
`ifdef BUS_CTL_ALARM_EN
    repeat (TMO - 1) tick();
    check("t6_pre_timeout", outs(), 8'b1001_0100);
    tick();
    check("t6_alarm_done", outs(), 8'b0001_1101);
    bus.rok = 1'b0; bus.req = 1'b0;
    tick();
    check("t6_idle", outs(), 8'b0000_0101);
`else
    repeat (TMO + 20) tick();
    check("t6_wait_release", outs(), 8'b1001_0100);
    bus.rok = 1'b0;
    wait_bit("t6_done_seen", B_DONE, 10, n);
    check("t6_done_no_alarm", outs(), 8'b0001_1100);
    bus.req = 1'b0;
    tick();
    check("t6_idle", outs(), 8'b0000_0100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
